// File: rtl/elastic_rr_merge_pkg.sv
// Shared constants and helpers for the elastic round-robin merge block.
package elastic_rr_merge_pkg;

    localparam int DEF_N      = 32'sd4;
    localparam int DEF_DATA_W = 32'sd8;

    // Number of bits needed to index 'value' distinct items (minimum 1).
    function automatic int clog2(input int value);
        int r;
        r = 32'sd1;
        for (int i = 1; i < 32; i++) begin
            r = ((32'sd1 << i) < value) ? i + 32'sd1 : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/elastic_rr_merge_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping modulo N.
module rr_pick
    import elastic_rr_merge_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan offsets from farthest to nearest so the nearest hit to ptr is kept last.
    always_comb begin
        logic [IDX_W:0] pos_v;
        logic           hit_v;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            pos_v = {1'b0, ptr} + (IDX_W+1)'(k);
            pos_v = (pos_v >= (IDX_W+1)'(N)) ? pos_v - (IDX_W+1)'(N) : pos_v;
            hit_v = req[pos_v[IDX_W-1:0]];
            grant = hit_v ? (N'(1) << pos_v[IDX_W-1:0]) : grant;
            idx   = hit_v ? pos_v[IDX_W-1:0] : idx;
            any   = hit_v | any;
        end
    end

endmodule

// File: rtl/elastic_rr_merge.sv
// N-to-1 elastic merge: round-robin grant into a single registered output slot
// that can emit and refill in the same cycle.
module elastic_rr_merge
    import elastic_rr_merge_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = clog2(N)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N*DATA_W-1:0] data_in,
    input  logic [N-1:0]        pvalid_in,
    output logic [N-1:0]        ready_out,
    output logic [DATA_W-1:0]   data_out,
    output logic [IDX_W-1:0]    index_out,
    output logic                valid_out,
    input  logic                nready_in
);

    logic [N-1:0]      grant_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              any_s;
    logic              free_s;
    logic              accept_s;
    logic [IDX_W-1:0]  ptr_next_s;
    logic [DATA_W-1:0] pick_data_s;

    logic              full_r;
    logic [DATA_W-1:0] data_r;
    logic [IDX_W-1:0]  index_r;
    logic [IDX_W-1:0]  ptr_r;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (pvalid_in),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (pick_idx_s),
        .any   (any_s)
    );

    // Handshake: the slot is free when empty or draining this cycle; nothing is accepted in reset.
    always_comb begin
        free_s    = ~full_r | nready_in;
        ready_out = grant_s & {N{free_s & rstn}};
        accept_s  = any_s & free_s & rstn;
    end

    // Pointer moves just past the winner so every other requester is ahead of it next time.
    always_comb begin
        if (pick_idx_s == IDX_W'(N - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = pick_idx_s + IDX_W'(1);
        end
    end

    // One-hot AND-OR mux of the granted channel's data.
    always_comb begin
        pick_data_s = '0;
        for (int i = 0; i < N; i++) begin
            pick_data_s = pick_data_s | (data_in[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
        end
    end

    // Output slot and round-robin pointer state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            full_r  <= 1'b0;
            data_r  <= '0;
            index_r <= '0;
            ptr_r   <= '0;
        end else if (accept_s) begin
            full_r  <= 1'b1;
            data_r  <= pick_data_s;
            index_r <= pick_idx_s;
            ptr_r   <= ptr_next_s;
        end else if (nready_in) begin
            full_r  <= 1'b0;
        end
    end

    assign valid_out = full_r;
    assign data_out  = data_r;
    assign index_out = index_r;

endmodule

// File: tb/tb_elastic_rr_merge.sv
// Bench for elastic_rr_merge: vector table, directed corner sequences and a random scoreboard run.
module tb_elastic_rr_merge;

    logic        clk;
    logic        rstn;
    logic [31:0] data_in;
    logic [3:0]  pvalid_in;
    logic [3:0]  ready_out;
    logic [7:0]  data_out;
    logic [1:0]  index_out;
    logic        valid_out;
    logic        nready_in;

    int n_chk;
    int errs;

    elastic_rr_merge #(.N(4), .DATA_W(8), .IDX_W(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .data_in   (data_in),
        .pvalid_in (pvalid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .index_out (index_out),
        .valid_out (valid_out),
        .nready_in (nready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rstn;
        logic [3:0] pv;
        logic       nr;
        logic [3:0] exp_rdy;
        logic       exp_v;
        logic [1:0] exp_idx;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl [14];

    logic       m_full;
    logic [1:0] m_ptr;
    logic [5:0] seq [4];
    int         wait_cnt [4];
    int         max_wait;
    int         n_acc;
    logic [9:0] sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_grant(input logic [3:0] pv, input logic [1:0] p);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (int'(p) + k) % 4;
            if (pv[j]) return 4'b0001 << j;
        end
        return 4'b0000;
    endfunction

    // One random cycle: new requests, check grant, pop emitted token, push accepted one.
    task automatic rand_step(input bit gen);
        logic [3:0] exp_rdy;
        logic [9:0] exp_tok;
        int         a;
        chk("rnd_valid", {31'd0, valid_out}, {31'd0, m_full});
        for (int i = 0; i < 4; i++) begin
            if (gen && !pvalid_in[i] && $urandom_range(0, 2) == 0) begin
                pvalid_in[i]          = 1'b1;
                data_in[i*8 +: 8]     = {2'(i), seq[i]};
            end
        end
        nready_in = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        exp_rdy = (!m_full || nready_in) ? exp_grant(pvalid_in, m_ptr) : 4'b0000;
        chk("rnd_ready", {28'd0, ready_out}, {28'd0, exp_rdy});
        if (valid_out && nready_in) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                errs++;
                $display("FAIL rnd_extra_token: got %0h expected none", {index_out, data_out});
            end else begin
                exp_tok = sb_q.pop_front();
                chk("rnd_token", {22'd0, index_out, data_out}, {22'd0, exp_tok});
            end
        end
        a = -1;
        for (int i = 0; i < 4; i++) if (exp_rdy[i] && pvalid_in[i]) a = i;
        if (a >= 0) begin
            sb_q.push_back({2'(a), data_in[a*8 +: 8]});
            n_acc++;
            for (int i = 0; i < 4; i++) begin
                if (i != a && pvalid_in[i]) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
            wait_cnt[a] = 0;
            m_ptr  = 2'(a + 1);
            m_full = 1'b1;
        end else if (nready_in) begin
            m_full = 1'b0;
        end
        tick();
        if (a >= 0) begin
            pvalid_in[a] = 1'b0;
            seq[a]       = seq[a] + 6'd1;
        end
    endtask

    initial begin
        n_chk     = 0;
        errs      = 0;
        rstn      = 1'b0;
        pvalid_in = 4'b1111;
        nready_in = 1'b1;
        data_in   = 32'h13121110;

        //          rstn  pv       nr    rdy      v     idx    data
        tbl[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        tbl[5]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
        tbl[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tbl[7]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        tbl[8]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        tbl[9]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        tbl[10] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[11] = '{1'b1, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h13};
        tbl[12] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h13};
        tbl[13] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};

        for (int r = 0; r < 14; r++) begin
            rstn      = tbl[r].rstn;
            pvalid_in = tbl[r].pv;
            nready_in = tbl[r].nr;
            #1;
            chk($sformatf("tbl%0d_ready", r), {28'd0, ready_out}, {28'd0, tbl[r].exp_rdy});
            tick();
            chk($sformatf("tbl%0d_valid", r), {31'd0, valid_out}, {31'd0, tbl[r].exp_v});
            if (tbl[r].exp_v || !tbl[r].rstn) begin
                chk($sformatf("tbl%0d_token", r), {22'd0, index_out, data_out},
                    {22'd0, tbl[r].exp_idx, tbl[r].exp_data});
            end
        end

        // Backpressure: hold 0xA5 from ch1, then emit and refill in one cycle.
        data_in   = 32'h1312A510;
        pvalid_in = 4'b0010;
        nready_in = 1'b0;
        #1;
        chk("bp_ready_load", {28'd0, ready_out}, 32'h2);
        tick();
        chk("bp_loaded", {21'd0, valid_out, index_out, data_out}, {21'd0, 1'b1, 2'd1, 8'hA5});
        data_in = 32'h13125A10;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_ready_blocked", {28'd0, ready_out}, 32'h0);
            tick();
            chk("bp_stable", {21'd0, valid_out, index_out, data_out}, {21'd0, 1'b1, 2'd1, 8'hA5});
        end
        nready_in = 1'b1;
        #1;
        chk("bp_ready_release", {28'd0, ready_out}, 32'h2);
        tick();
        chk("bp_refill", {21'd0, valid_out, index_out, data_out}, {21'd0, 1'b1, 2'd1, 8'h5A});
        pvalid_in = 4'b0000;
        tick();
        chk("bp_drained", {31'd0, valid_out}, 32'h0);

        // Reset while holding 0x3C: token must vanish and pointer return to 0.
        data_in   = 32'h3C121110;
        pvalid_in = 4'b1000;
        nready_in = 1'b0;
        #1;
        chk("rst_ready_load", {28'd0, ready_out}, 32'h8);
        tick();
        chk("rst_loaded", {24'd0, data_out}, 32'h3C);
        rstn      = 1'b0;
        pvalid_in = 4'b0000;
        #1;
        chk("rst_ready_in_reset", {28'd0, ready_out}, 32'h0);
        tick();
        chk("rst_cleared", {21'd0, valid_out, index_out, data_out}, 32'h0);
        rstn      = 1'b1;
        nready_in = 1'b1;
        tick();
        chk("rst_no_emit", {31'd0, valid_out}, 32'h0);
        pvalid_in = 4'b1111;
        data_in   = 32'h13121110;
        #1;
        chk("rst_ptr_zero", {28'd0, ready_out}, 32'h1);

        // Random run against the scoreboard.
        rstn      = 1'b0;
        pvalid_in = 4'b0000;
        tick();
        rstn     = 1'b1;
        m_full   = 1'b0;
        m_ptr    = 2'd0;
        max_wait = 0;
        n_acc    = 0;
        for (int i = 0; i < 4; i++) begin
            seq[i]      = 6'd0;
            wait_cnt[i] = 0;
        end
        for (int c = 0; c < 10000; c++) rand_step(1'b1);
        for (int c = 0; c < 8; c++) rand_step(1'b0);
        chk("rnd_sb_empty", sb_q.size(), 32'd0);
        chk("rnd_max_wait_ok", {31'd0, max_wait <= 3}, 32'd1);
        chk("rnd_activity", {31'd0, n_acc > 1000}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end

endmodule
